// File: rtl/hazard_frame_loader.sv
// Collects per-frame hazard bounding boxes into a shadow bank and commits them atomically
// to the output buses, so downstream logic always sees a complete, stable frame.
module hazard_frame_loader #(
  parameter int unsigned MAX_HAZ = 16,
  parameter int unsigned COORD_W = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic                       in_eof,
  input  logic [COORD_W-1:0]         in_top,
  input  logic [COORD_W-1:0]         in_left,
  input  logic [COORD_W-1:0]         in_bottom,
  input  logic [COORD_W-1:0]         in_right,
  output logic [MAX_HAZ*COORD_W-1:0] top_bus,
  output logic [MAX_HAZ*COORD_W-1:0] left_bus,
  output logic [MAX_HAZ*COORD_W-1:0] bottom_bus,
  output logic [MAX_HAZ*COORD_W-1:0] right_bus,
  output logic [3:0]                 num_hazards,
  output logic                       frame_valid,
  output logic                       overflow,
  output logic                       bad_box,
  output logic                       sof_err
);

  // Slot count is bounded by both the bank depth and the 4-bit num_hazards field.
  localparam int unsigned Cap = (MAX_HAZ < 15) ? MAX_HAZ : 15;

  typedef enum logic [1:0] {StIdle, StFill, StCommit} state_e;

  state_e state_q, state_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic ovf_q, ovf_d;
  logic bad_q, bad_d;
  logic sof_err_d;
  logic wr_en;
  logic [3:0] wr_idx;
  logic accept;
  logic box_ok;

  logic [COORD_W-1:0] sh_top    [MAX_HAZ];
  logic [COORD_W-1:0] sh_left   [MAX_HAZ];
  logic [COORD_W-1:0] sh_bottom [MAX_HAZ];
  logic [COORD_W-1:0] sh_right  [MAX_HAZ];

  assign in_ready = (state_q != StCommit);
  assign accept   = in_valid && in_ready;
  assign box_ok   = (in_top <= in_bottom) && (in_left <= in_right);

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    ovf_d     = ovf_q;
    bad_d     = bad_q;
    sof_err_d = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = 4'd0;
    unique case (state_q)
      StIdle, StFill: begin
        if (accept) begin
          if (in_sof) begin
            // A new sof always restarts the frame, discarding any partial one.
            wr_en    = box_ok;
            wr_idx   = 4'd0;
            wr_cnt_d = box_ok ? 4'd1 : 4'd0;
            ovf_d    = 1'b0;
            bad_d    = !box_ok;
            state_d  = in_eof ? StCommit : StFill;
          end else if (state_q == StFill) begin
            if (!box_ok) begin
              bad_d = 1'b1;
            end else if (wr_cnt_q == 4'(Cap)) begin
              ovf_d = 1'b1;
            end else begin
              wr_en    = 1'b1;
              wr_idx   = wr_cnt_q;
              wr_cnt_d = wr_cnt_q + 4'd1;
            end
            state_d = in_eof ? StCommit : StFill;
          end else begin
            sof_err_d = 1'b1;
          end
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_cnt_q <= 4'd0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
      for (int unsigned i = 0; i < MAX_HAZ; i++) begin
        sh_top[i]    <= '0;
        sh_left[i]   <= '0;
        sh_bottom[i] <= '0;
        sh_right[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
      for (int unsigned i = 0; i < MAX_HAZ; i++) begin
        if (wr_en && (32'(wr_idx) == i)) begin
          sh_top[i]    <= in_top;
          sh_left[i]   <= in_left;
          sh_bottom[i] <= in_bottom;
          sh_right[i]  <= in_right;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_bus     <= '0;
      left_bus    <= '0;
      bottom_bus  <= '0;
      right_bus   <= '0;
      num_hazards <= 4'd0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      bad_box     <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      sof_err     <= sof_err_d;
      frame_valid <= (state_q == StCommit);
      if (state_q == StCommit) begin
        // Slots past wr_cnt may hold stale data from a discarded frame; mask them.
        for (int unsigned i = 0; i < MAX_HAZ; i++) begin
          if (i < 32'(wr_cnt_q)) begin
            top_bus[i*COORD_W +: COORD_W]    <= sh_top[i];
            left_bus[i*COORD_W +: COORD_W]   <= sh_left[i];
            bottom_bus[i*COORD_W +: COORD_W] <= sh_bottom[i];
            right_bus[i*COORD_W +: COORD_W]  <= sh_right[i];
          end else begin
            top_bus[i*COORD_W +: COORD_W]    <= '0;
            left_bus[i*COORD_W +: COORD_W]   <= '0;
            bottom_bus[i*COORD_W +: COORD_W] <= '0;
            right_bus[i*COORD_W +: COORD_W]  <= '0;
          end
        end
        num_hazards <= wr_cnt_q;
        overflow    <= ovf_q;
        bad_box     <= bad_q;
      end
    end
  end

endmodule

// File: tb/tb_hazard_frame_loader.sv
// Self-checking bench for hazard_frame_loader: directed vectors, corner sequences and
// random traffic against a frame-level queue model.
module tb_hazard_frame_loader;

  localparam int NH = 16;
  localparam int CW = 11;
  localparam int BW = NH * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
  logic [CW-1:0] in_top = '0, in_left = '0, in_bottom = '0, in_right = '0;
  logic in_ready;
  logic [BW-1:0] top_bus, left_bus, bottom_bus, right_bus;
  logic [3:0] num_hazards;
  logic frame_valid, overflow, bad_box, sof_err;

  hazard_frame_loader #(.MAX_HAZ(NH), .COORD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_eof(in_eof), .in_top(in_top), .in_left(in_left),
    .in_bottom(in_bottom), .in_right(in_right), .top_bus(top_bus), .left_bus(left_bus),
    .bottom_bus(bottom_bus), .right_bus(right_bus), .num_hazards(num_hazards),
    .frame_valid(frame_valid), .overflow(overflow), .bad_box(bad_box), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] t, l, b, r;
  } box_t;

  typedef struct {
    logic [CW-1:0] t, l, b, r;
    logic [3:0]    n;
    logic          bad;
    logic [CW-1:0] top0;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Frame-level model: good boxes of the open frame, in arrival order.
  box_t q[$];
  logic m_in_frame, m_ready, m_bad;
  logic [BW-1:0] e_top, e_left, e_bottom, e_right;
  logic [3:0] e_num;
  logic e_ovf, e_bad;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_in_frame = 1'b0;
    m_ready = 1'b1;
    m_bad = 1'b0;
    e_top = '0; e_left = '0; e_bottom = '0; e_right = '0;
    e_num = 4'd0; e_ovf = 1'b0; e_bad = 1'b0;
  endtask

  task automatic check_outputs(input logic fv, input logic se);
    chk("frame_valid", BW'(frame_valid), BW'(fv));
    chk("sof_err", BW'(sof_err), BW'(se));
    chk("num_hazards", BW'(num_hazards), BW'(e_num));
    chk("overflow", BW'(overflow), BW'(e_ovf));
    chk("bad_box", BW'(bad_box), BW'(e_bad));
    chk("top_bus", top_bus, e_top);
    chk("left_bus", left_bus, e_left);
    chk("bottom_bus", bottom_bus, e_bottom);
    chk("right_bus", right_bus, e_right);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic v, input logic s, input logic e,
                       input logic [CW-1:0] t, input logic [CW-1:0] l,
                       input logic [CW-1:0] b, input logic [CW-1:0] r);
    logic acc, commit_now, se_exp;
    int n;
    in_valid = v; in_sof = s; in_eof = e;
    in_top = t; in_left = l; in_bottom = b; in_right = r;
    #1;
    chk("in_ready", BW'(in_ready), BW'(m_ready));
    acc = v && m_ready;
    commit_now = !m_ready;
    se_exp = 1'b0;
    if (acc) begin
      if (s || m_in_frame) begin
        if (s) begin
          q.delete();
          m_bad = 1'b0;
        end
        m_in_frame = 1'b1;
        if ((t > b) || (l > r)) m_bad = 1'b1;
        else q.push_back('{t: t, l: l, b: b, r: r});
        if (e) begin
          m_in_frame = 1'b0;
          m_ready = 1'b0;
        end
      end else begin
        se_exp = 1'b1;
      end
    end
    if (commit_now) begin
      m_ready = 1'b1;
      n = (q.size() > 15) ? 15 : q.size();
      e_num = 4'(n);
      e_ovf = (q.size() > 15);
      e_bad = m_bad;
      e_top = '0; e_left = '0; e_bottom = '0; e_right = '0;
      for (int i = 0; i < n; i++) begin
        e_top[i*CW +: CW] = q[i].t;
        e_left[i*CW +: CW] = q[i].l;
        e_bottom[i*CW +: CW] = q[i].b;
        e_right[i*CW +: CW] = q[i].r;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(commit_now, se_exp);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 11'd0, 11'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [7];

  initial begin
    logic [CW-1:0] t, l, b, r;
    model_reset();
    tbl[0] = '{t: 11'd5,    l: 11'd5,   b: 11'd6,    r: 11'd6,    n: 4'd1, bad: 1'b0, top0: 11'd5};
    tbl[1] = '{t: 11'd0,    l: 11'd0,   b: 11'd0,    r: 11'd0,    n: 4'd1, bad: 1'b0, top0: 11'd0};
    tbl[2] = '{t: 11'd2047, l: 11'd0,   b: 11'd2047, r: 11'd2047, n: 4'd1, bad: 1'b0,
               top0: 11'd2047};
    tbl[3] = '{t: 11'd7,    l: 11'd0,   b: 11'd6,    r: 11'd0,    n: 4'd0, bad: 1'b1, top0: 11'd0};
    tbl[4] = '{t: 11'd0,    l: 11'd9,   b: 11'd0,    r: 11'd8,    n: 4'd0, bad: 1'b1, top0: 11'd0};
    tbl[5] = '{t: 11'd1,    l: 11'd1,   b: 11'd0,    r: 11'd0,    n: 4'd0, bad: 1'b1, top0: 11'd0};
    tbl[6] = '{t: 11'd100,  l: 11'd200, b: 11'd100,  r: 11'd200,  n: 4'd1, bad: 1'b0,
               top0: 11'd100};

    #2;
    check_outputs(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat frames from the table.
    foreach (tbl[k]) begin
      cycle(1'b1, 1'b1, 1'b1, tbl[k].t, tbl[k].l, tbl[k].b, tbl[k].r);
      idle();
      chk("tbl_num", BW'(num_hazards), BW'(tbl[k].n));
      chk("tbl_bad", BW'(bad_box), BW'(tbl[k].bad));
      chk("tbl_top0", BW'(top_bus[CW-1:0]), BW'(tbl[k].top0));
    end

    // Two-beat frame.
    cycle(1'b1, 1'b1, 1'b0, 11'd10, 11'd20, 11'd200, 11'd300);
    cycle(1'b1, 1'b0, 1'b1, 11'd100, 11'd900, 11'd300, 11'd1230);
    idle();
    chk("two_num", BW'(num_hazards), BW'(4'd2));
    chk("two_top0", BW'(top_bus[CW-1:0]), BW'(11'd10));
    chk("two_right1", BW'(right_bus[2*CW-1:CW]), BW'(11'd1230));
    chk("two_hi_zero", BW'(top_bus[BW-1:2*CW]), BW'(0));
    idle();

    // Single sof+eof beat: ready drops for exactly the commit cycle.
    cycle(1'b1, 1'b1, 1'b1, 11'd5, 11'd5, 11'd6, 11'd6);
    chk("single_ready_low", BW'(in_ready), BW'(1'b0));
    idle();
    chk("single_ready_back", BW'(in_ready), BW'(1'b1));

    // 17 beats: capacity saturates at 15.
    for (int k = 1; k <= 17; k++)
      cycle(1'b1, k == 1, k == 17, 11'(k), 11'(k), 11'(k + 100), 11'(k + 200));
    idle();
    chk("cap_num", BW'(num_hazards), BW'(4'd15));
    chk("cap_ovf", BW'(overflow), BW'(1'b1));
    chk("cap_slot14", BW'(top_bus[14*CW +: CW]), BW'(11'd15));

    // Inverted box in the middle of a three-beat frame.
    cycle(1'b1, 1'b1, 1'b0, 11'd1, 11'd2, 11'd3, 11'd4);
    cycle(1'b1, 1'b0, 1'b0, 11'd50, 11'd2, 11'd40, 11'd4);
    cycle(1'b1, 1'b0, 1'b1, 11'd7, 11'd8, 11'd9, 11'd10);
    idle();
    chk("bad_num", BW'(num_hazards), BW'(4'd2));
    chk("bad_flag", BW'(bad_box), BW'(1'b1));
    chk("bad_top1", BW'(top_bus[2*CW-1:CW]), BW'(11'd7));

    // Beat without sof in idle, then a partial frame restarted by a new sof.
    cycle(1'b1, 1'b0, 1'b0, 11'd1, 11'd1, 11'd2, 11'd2);
    chk("sof_err_pulse", BW'(sof_err), BW'(1'b1));
    cycle(1'b1, 1'b1, 1'b0, 11'd3, 11'd3, 11'd4, 11'd4);
    cycle(1'b1, 1'b0, 1'b0, 11'd5, 11'd5, 11'd6, 11'd6);
    cycle(1'b1, 1'b1, 1'b1, 11'd8, 11'd9, 11'd10, 11'd11);
    idle();
    chk("restart_num", BW'(num_hazards), BW'(4'd1));
    chk("restart_top0", BW'(top_bus[CW-1:0]), BW'(11'd8));

    // Reset in the middle of a frame.
    cycle(1'b1, 1'b1, 1'b0, 11'd1, 11'd1, 11'd2, 11'd2);
    cycle(1'b1, 1'b0, 1'b0, 11'd3, 11'd3, 11'd4, 11'd4);
    cycle(1'b1, 1'b0, 1'b0, 11'd5, 11'd5, 11'd6, 11'd6);
    do_reset();
    idle();
    idle();
    cycle(1'b1, 1'b1, 1'b0, 11'd20, 11'd21, 11'd22, 11'd23);
    cycle(1'b1, 1'b0, 1'b1, 11'd30, 11'd31, 11'd32, 11'd33);
    idle();
    chk("post_rst_num", BW'(num_hazards), BW'(4'd2));

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      t = 11'($urandom_range(0, 2047));
      l = 11'($urandom_range(0, 2047));
      if ($urandom % 10 == 0) begin
        b = 11'($urandom_range(0, 2047));
        r = 11'($urandom_range(0, 2047));
      end else begin
        b = 11'($urandom_range(int'(t), 2047));
        r = 11'($urandom_range(int'(l), 2047));
      end
      cycle(($urandom % 4) != 0, ($urandom % 14) == 0, ($urandom % 20) == 0, t, l, b, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_frame_loader.md
HAZARD_FRAME_LOADER -- requirements
Module: hazard_frame_loader

Interface
REQ-001 SHALL have parameter MAX_HAZ, default 16, meaning number of hazard slots per frame.
REQ-002 SHALL have parameter COORD_W, default 11, meaning bit width of one bounding-box coordinate.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream hazard beat valid.
REQ-006 SHALL have port in_ready  output  1  loader can accept a beat this cycle.
REQ-007 SHALL have port in_sof  input  1  beat is first hazard of a frame.
REQ-008 SHALL have port in_eof  input  1  beat is last hazard of a frame.
REQ-009 SHALL have ports in_top, in_left, in_bottom, in_right  input  COORD_W each  bounding box of the beat.
REQ-010 SHALL have ports top_bus, left_bus, bottom_bus, right_bus  output  MAX_HAZ*COORD_W each  committed boxes; slot i at bits [COORD_W*i+COORD_W-1 : COORD_W*i].
REQ-011 SHALL have port num_hazards  output  4  count of valid slots in the committed frame.
REQ-012 SHALL have port frame_valid  output  1  one-cycle pulse when a new frame is committed.
REQ-013 SHALL have port overflow  output  1  sticky per frame: beats dropped because 15 slots were already filled.
REQ-014 SHALL have port bad_box  output  1  sticky per frame: beats dropped for top>bottom or left>right.
REQ-015 SHALL have port sof_err  output  1  one-cycle pulse: beat without in_sof received in IDLE and dropped.

Function
REQ-016 SHALL double-buffer: beats fill a shadow bank; outputs change only at commit, so the hazard encoder sees a stable frame.
REQ-017 SHALL implement FSM states IDLE, FILL, COMMIT.
REQ-018 SHALL accept a beat when in_valid && in_ready; in_ready = 1 in IDLE and FILL, 0 in COMMIT.
REQ-019 IDLE: accepted beat with in_sof -> write slot 0, wr_cnt=1 (0 if the box is dropped), clear shadow flags; go to FILL, or to COMMIT if in_eof is also set.
REQ-020 IDLE: accepted beat without in_sof -> drop it, pulse sof_err, stay in IDLE.
REQ-021 FILL: accepted beat with in_sof -> discard the partial frame, restart as in REQ-019.
REQ-022 FILL: accepted beat without in_sof -> write slot wr_cnt, increment wr_cnt; go to COMMIT if in_eof.
REQ-023 Drop rule: a beat with top>bottom or left>right SHALL NOT be written, and SHALL set shadow bad_box; in_eof on it still ends the frame.
REQ-024 Capacity: wr_cnt saturates at 15 (width of num_hazards); further beats are not written and set shadow overflow; in_eof still ends the frame.
REQ-025 COMMIT (exactly one cycle): at the next edge, copy shadow slots 0..wr_cnt-1 to the output buses, force slots wr_cnt..MAX_HAZ-1 to 0, set num_hazards=wr_cnt, load overflow/bad_box from the shadow flags, assert frame_valid for one cycle, go to IDLE.
REQ-026 Latency: eof beat accepted at edge k -> outputs and frame_valid updated at edge k+1; in_ready low only in the cycle between edges k and k+1.
REQ-027 A frame whose beats are all dropped SHALL commit with num_hazards=0 and all buses zero.
REQ-028 Coordinates SHALL pass through unmodified (no clipping or swapping).
REQ-029 Outputs SHALL hold the last committed frame until the next commit.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, wr_cnt 0, shadow bank and flags 0, all buses 0, num_hazards 0, frame_valid 0, overflow 0, bad_box 0, sof_err 0.
REQ-031 in_ready SHALL be 1 from the first clock cycle after rst_n deasserts.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; no commit follows.

Verification
REQ-033 Beat (sof,10,20,200,300) then (eof,100,900,300,1230) -> one frame_valid pulse; num_hazards=2; slot0 top=10, slot1 right=1230; slots 2-15 = 0.
REQ-034 Single beat with sof=eof=1, box (5,5,6,6) -> commit next edge; num_hazards=1; in_ready low exactly one cycle.
REQ-035 Frame of 17 valid beats -> num_hazards=15; overflow=1; slots 0-14 hold beats 1-15.
REQ-036 Beat with top=50, bottom=40 inside a 3-beat frame -> num_hazards=2; bad_box=1; remaining boxes packed into slots 0-1.
REQ-037 Beat without sof in IDLE -> sof_err pulse, no state change; 2 beats then new sof -> first frame discarded, outputs unchanged until the new eof.
REQ-038 rst_n pulsed low after 3 beats of a frame -> all outputs 0, no frame_valid; next complete frame commits normally.
